// File: rtl/boid_seq_pkg.sv
// boid_seq_pkg: shared types and constants for the boid memory sequencer
//   seq_state_e : sequencer FSM states
//   boid_t      : packed {x, y, vx, vy}, 16.16 fixed point, 128 bits
//   X_MAX_FX / Y_MAX_FX : screen bounds used by the optional position clamp
package boid_seq_pkg;

    localparam logic [31:0] X_MAX_FX = 32'd639 << 16;
    localparam logic [31:0] Y_MAX_FX = 32'd479 << 16;

    typedef enum logic [2:0] {IDLE, LOAD_RD, LOAD, ITR, WB, SWAP} seq_state_e;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] vx;
        logic [31:0] vy;
    } boid_t;

    function automatic logic [31:0] clamp_fx(input logic [31:0] v, input logic [31:0] hi);
        return ($signed(v) < 0) ? 32'd0 : ($signed(v) > $signed(hi)) ? hi : v;
    endfunction

endpackage

// File: rtl/boid_bank_ram.sv
// boid_bank_ram: one boid state bank, one write port, two synchronous read ports
//   clk, rst_n        : clock, async active-low reset (clears read registers only)
//   we, waddr, wdata  : write port, contents update the cycle after we
//   raddr_a / rdata_a : sequencer read port, 1-cycle latency
//   raddr_b / rdata_b : display read port, 1-cycle latency
module boid_bank_ram
    import boid_seq_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  boid_t         wdata,
    input  logic [AW-1:0] raddr_a,
    output boid_t         rdata_a,
    input  logic [AW-1:0] raddr_b,
    output boid_t         rdata_b
);

    boid_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/boid_mem_sequencer.sv
// boid_mem_sequencer: ping-pong boid state store feeding the boid accelerator each frame
//   clk, reset            : clock, async active-low reset
//   start / busy / done   : frame control (start sampled in IDLE, done pulses in SWAP)
//   init_*                : host writes into the front bank while idle
//   r_en_tot, r_en_itr, wb_en, *_in_xcel : accelerator drive (load / neighbour / writeback)
//   *_out_xcel            : updated boid from accelerator, stored to the back bank in WB
//   disp_idx, disp_x/y    : front-bank position read, 1-cycle latency
//   Optional macro BOID_POS_CLAMP_EN clamps stored x/y to the screen bounds.
module boid_mem_sequencer
    import boid_seq_pkg::*;
#(
    parameter int NUM_BOIDS = 32,
    parameter int IDX_W     = $clog2(NUM_BOIDS),
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              init_we,
    input  logic [IDX_W-1:0]  init_idx,
    input  logic [DATA_W-1:0] init_x,
    input  logic [DATA_W-1:0] init_y,
    input  logic [DATA_W-1:0] init_vx,
    input  logic [DATA_W-1:0] init_vy,
    output logic              r_en_tot,
    output logic              r_en_itr,
    output logic [6:0]        wb_en,
    output logic [DATA_W-1:0] x_in_xcel,
    output logic [DATA_W-1:0] y_in_xcel,
    output logic [DATA_W-1:0] vx_in_xcel,
    output logic [DATA_W-1:0] vy_in_xcel,
    input  logic [DATA_W-1:0] x_out_xcel,
    input  logic [DATA_W-1:0] y_out_xcel,
    input  logic [DATA_W-1:0] vx_out_xcel,
    input  logic [DATA_W-1:0] vy_out_xcel,
    input  logic [IDX_W-1:0]  disp_idx,
    output logic [DATA_W-1:0] disp_x,
    output logic [DATA_W-1:0] disp_y
);

    seq_state_e       state, state_nx;
    logic [IDX_W-1:0] i_q, k_q, rd_addr, wr_addr;
    logic             bank_sel, rd_sel_q, init_wr, wb_wr, presenting;
    boid_t            rd0, rd1, dd0, dd1, rd_boid, wb_boid, wr_boid;

    assign busy       = state != IDLE;
    assign done       = state == SWAP;
    assign r_en_tot   = state == LOAD;
    assign r_en_itr   = state == ITR && k_q != i_q;
    assign wb_en      = {6'b0, state == WB};
    assign presenting = state == LOAD || state == ITR;

    assign init_wr = init_we && state == IDLE;
    assign wb_wr   = state == WB;
    assign wr_addr = wb_wr ? i_q : init_idx;

`ifdef BOID_POS_CLAMP_EN
    assign wb_boid = {clamp_fx(x_out_xcel, X_MAX_FX), clamp_fx(y_out_xcel, Y_MAX_FX),
                      vx_out_xcel, vy_out_xcel};
`else
    assign wb_boid = {x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel};
`endif
    assign wr_boid = wb_wr ? wb_boid : {init_x, init_y, init_vx, init_vy};

    // Read address runs one step ahead of the data presented to the accelerator.
    assign rd_addr = state == LOAD_RD ? i_q : state == LOAD ? '0 : k_q + 1'b1;

    // Bank select is registered alongside the RAM read so a read issued in the
    // SWAP cycle still returns the bank that was front when it was issued.
    assign rd_boid = rd_sel_q ? rd1 : rd0;
    assign disp_x  = rd_sel_q ? dd1.x : dd0.x;
    assign disp_y  = rd_sel_q ? dd1.y : dd0.y;

    assign x_in_xcel  = presenting ? rd_boid.x  : '0;
    assign y_in_xcel  = presenting ? rd_boid.y  : '0;
    assign vx_in_xcel = presenting ? rd_boid.vx : '0;
    assign vy_in_xcel = presenting ? rd_boid.vy : '0;

    // bank_sel names the front bank; host writes go to front, writeback to back.
    boid_bank_ram #(.DEPTH(NUM_BOIDS), .AW(IDX_W)) u_bank0 (
        .clk(clk), .rst_n(reset),
        .we((init_wr && !bank_sel) || (wb_wr && bank_sel)),
        .waddr(wr_addr), .wdata(wr_boid),
        .raddr_a(rd_addr), .rdata_a(rd0),
        .raddr_b(disp_idx), .rdata_b(dd0)
    );

    boid_bank_ram #(.DEPTH(NUM_BOIDS), .AW(IDX_W)) u_bank1 (
        .clk(clk), .rst_n(reset),
        .we((init_wr && bank_sel) || (wb_wr && !bank_sel)),
        .waddr(wr_addr), .wdata(wr_boid),
        .raddr_a(rd_addr), .rdata_a(rd1),
        .raddr_b(disp_idx), .rdata_b(dd1)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            i_q      <= '0;
            k_q      <= '0;
            bank_sel <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state    <= state_nx;
            rd_sel_q <= bank_sel;
            k_q      <= state == ITR ? k_q + 1'b1 : '0;
            if (state == IDLE) i_q <= '0;
            else if (state == WB) i_q <= i_q + 1'b1;
            if (state == SWAP) bank_sel <= ~bank_sel;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LOAD_RD : IDLE;
            LOAD_RD: state_nx = LOAD;
            LOAD:    state_nx = ITR;
            ITR:     state_nx = k_q == IDX_W'(NUM_BOIDS - 1) ? WB : ITR;
            WB:      state_nx = i_q == IDX_W'(NUM_BOIDS - 1) ? SWAP : LOAD_RD;
            SWAP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule
